pipe_reg_mw: RTL and testbench
==============================

// Module: pipe_reg_mw
// PURPOSE
// - Parametrised MEM->WB pipeline register: carries ALU result, load data, PC+4, Rd and WB controls.
// - DEPTH identical register stages, each with a valid bit; supports stall (hold) and flush (bubble).
// - Sits between the data-memory stage and the writeback mux/register file.
// PARAMETERS
// DATA_WIDTH  32  width of ALUResult, ReadData and PCPlus4 fields
// ADDR_WIDTH  5   width of destination register index Rd
// SRC_WIDTH   2   width of ResultSrc control field
// DEPTH       1   number of register stages, legal 1..4; any other value is an elaboration error
// PORTS
// clk           in   1           clock, all state updates on rising edge
// rst           in   1           asynchronous, active-high reset
// StallW        in   1           1 = hold every stage's contents this cycle
// FlushW        in   1           1 = invalidate every stage this cycle
// ValidM        in   1           MEM-stage instruction is valid
// RegWriteM     in   1           register-file write enable from MEM
// ResultSrcM    in   SRC_WIDTH   writeback source select from MEM
// RdM           in   ADDR_WIDTH  destination register from MEM
// ALUResultM    in   DATA_WIDTH  ALU result from MEM
// ReadDataM     in   DATA_WIDTH  data-memory read data from MEM
// PCPlus4M      in   DATA_WIDTH  PC+4 from MEM
// ValidW        out  1           last stage holds a valid instruction
// RegWriteW     out  1           RegWrite of last stage, already ANDed with its valid bit
// ResultSrcW    out  SRC_WIDTH   last-stage ResultSrc
// RdW           out  ADDR_WIDTH  last-stage Rd
// ALUResultW    out  DATA_WIDTH  last-stage ALU result
// ReadDataW     out  DATA_WIDTH  last-stage read data
// PCPlus4W      out  DATA_WIDTH  last-stage PC+4
// StallCntW     out  32          (PIPE_PERF_EN only) cycles with StallW=1 and FlushW=0
// BubbleCntW    out  32          (PIPE_PERF_EN only) cycles with ValidW=0, counted after reset release
// BEHAVIOUR
// - Reset (async, rst=1): every stage's valid, control and data fields = 0; all outputs 0 immediately.
// - Latency: an input accepted at edge n appears on the outputs after DEPTH rising edges.
// - Per edge, highest priority first:
//   - FlushW=1: every stage valid=0, RegWrite=0, all other fields=0. Inputs are discarded. Flush overrides stall.
//   - StallW=1: every stage keeps its contents; inputs are discarded. Upstream must hold its own inputs.
//   - Else: stage0 <= inputs with valid=ValidM; stage k <= stage k-1.
// - When ValidM=0, the MEM-side fields are still captured.
//   - RegWriteW is forced 0 for that slot because RegWriteW = RegWrite & valid of the last stage.
// - No combinational path from any input to any output; all outputs are driven directly from the last stage.
// - Reset asserted mid-stall or mid-flush: reset wins; state returns to all-zero asynchronously.
// - Data fields are passed through verbatim, with no width conversion.
// CONFIGURATION
// - PIPE_PERF_EN defined: StallCntW and BubbleCntW ports and their counters exist.
//   - Both counters are 32-bit, reset to 0, and saturate at 32'hFFFF_FFFF (no wrap).
//   - StallCntW increments on each edge where StallW=1 and FlushW=0.
//   - BubbleCntW increments on each edge where the sampled ValidW=0.
// - PIPE_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
// - Reset: hold rst=1 with random inputs -> all outputs 0; release rst -> outputs stay 0 until the first valid input has traversed.
// - DEPTH=1 stream: ValidM=1, ALUResultM=32'h0000_0010, RdM=5, RegWriteM=1 -> next cycle ALUResultW=32'h10, RdW=5, RegWriteW=1, ValidW=1.
// - DEPTH=3 latency: one valid item with PCPlus4M=32'h104, then ValidM=0 -> PCPlus4W=32'h104 with ValidW=1 exactly 3 edges later, ValidW=0 otherwise.
// - Stall: StallW=1 for 2 cycles while the inputs change -> outputs frozen, then the pipeline resumes.
//   - With PIPE_PERF_EN, StallCntW increments by 2.
// - Flush with stall: StallW=1 and FlushW=1 on the same edge with a valid item in flight -> ValidW=0, RegWriteW=0, ALUResultW=0, and the item never appears.
// - Invalid slot: ValidM=0, RegWriteM=1, RdM=7 -> RegWriteW=0, ValidW=0, RdW=7.
//   - With PIPE_PERF_EN, BubbleCntW increments.

Source files
------------

// File: rtl/pipe_reg_mw_if.sv
// MEM->WB bus bundle: MEM-side fields into the pipeline register, WB-side fields out of it.
// master = MEM stage (drives *M, observes *W), slave = the pipeline register.
interface pipe_reg_mw_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int SRC_WIDTH  = 2
);
    logic                  ValidM;
    logic                  RegWriteM;
    logic [SRC_WIDTH-1:0]  ResultSrcM;
    logic [ADDR_WIDTH-1:0] RdM;
    logic [DATA_WIDTH-1:0] ALUResultM;
    logic [DATA_WIDTH-1:0] ReadDataM;
    logic [DATA_WIDTH-1:0] PCPlus4M;

    logic                  ValidW;
    logic                  RegWriteW;
    logic [SRC_WIDTH-1:0]  ResultSrcW;
    logic [ADDR_WIDTH-1:0] RdW;
    logic [DATA_WIDTH-1:0] ALUResultW;
    logic [DATA_WIDTH-1:0] ReadDataW;
    logic [DATA_WIDTH-1:0] PCPlus4W;

    modport master (
        output ValidM, RegWriteM, ResultSrcM, RdM, ALUResultM, ReadDataM, PCPlus4M,
        input  ValidW, RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W
    );

    modport slave (
        input  ValidM, RegWriteM, ResultSrcM, RdM, ALUResultM, ReadDataM, PCPlus4M,
        output ValidW, RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W
    );
endinterface

// File: rtl/pipe_reg_mw.sv
// MEM->WB pipeline register, DEPTH identical stages with valid bit, stall (hold) and flush (bubble).
// Optional feature macro: PIPE_PERF_EN adds saturating stall / bubble performance counters.
// Handshake: no ready/valid back-pressure; StallW holds all stages, FlushW zeroes all stages
// (flush beats stall), otherwise every stage advances by one on each rising edge.
module pipe_reg_mw #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int SRC_WIDTH  = 2,
    parameter int DEPTH      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallW,
    input  logic              FlushW,
`ifdef PIPE_PERF_EN
    output logic [31:0]       StallCntW,
    output logic [31:0]       BubbleCntW,
`endif
    pipe_reg_mw_if.slave      bus
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_reg_mw: DEPTH must be in 1..4");
        end
    endgenerate

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic [SRC_WIDTH-1:0]  src;
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] alu;
        logic [DATA_WIDTH-1:0] rdata;
        logic [DATA_WIDTH-1:0] pc4;
    } stage_t;

    stage_t stage_q [DEPTH];
    stage_t stage_d [DEPTH];
    stage_t in_stage;

    // Invalid MEM slots are still captured; only the writeback enable is qualified by valid.
    always_comb begin
        in_stage          = '0;
        in_stage.valid    = bus.ValidM;
        in_stage.regwrite = bus.RegWriteM;
        in_stage.src      = bus.ResultSrcM;
        in_stage.rd       = bus.RdM;
        in_stage.alu      = bus.ALUResultM;
        in_stage.rdata    = bus.ReadDataM;
        in_stage.pc4      = bus.PCPlus4M;
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (FlushW) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] = '0;
            end
        end else if (!StallW) begin
            stage_d[0] = in_stage;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign bus.ValidW     = stage_q[DEPTH-1].valid;
    assign bus.RegWriteW  = stage_q[DEPTH-1].regwrite & stage_q[DEPTH-1].valid;
    assign bus.ResultSrcW = stage_q[DEPTH-1].src;
    assign bus.RdW        = stage_q[DEPTH-1].rd;
    assign bus.ALUResultW = stage_q[DEPTH-1].alu;
    assign bus.ReadDataW  = stage_q[DEPTH-1].rdata;
    assign bus.PCPlus4W   = stage_q[DEPTH-1].pc4;

`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (StallW && !FlushW && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!stage_q[DEPTH-1].valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign StallCntW  = stall_cnt_q;
    assign BubbleCntW = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_mw.sv
// Directed bench for pipe_reg_mw: a DEPTH=1 and a DEPTH=3 instance share one stimulus stream.
module tb_pipe_reg_mw;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SW = 2;
  localparam int EW = 2 + SW + AW + 3 * DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic StallW, FlushW;
  logic in_valid, in_rw;
  logic [SW-1:0] in_src;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_alu, in_rdata, in_pc4;

  pipe_reg_mw_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRC_WIDTH(SW)) bus1 ();
  pipe_reg_mw_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRC_WIDTH(SW)) bus3 ();

`ifdef PIPE_PERF_EN
  logic [31:0] sc1, bc1, sc3, bc3;
`endif

  pipe_reg_mw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRC_WIDTH(SW), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW),
`ifdef PIPE_PERF_EN
    .StallCntW(sc1), .BubbleCntW(bc1),
`endif
    .bus(bus1.slave)
  );

  pipe_reg_mw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRC_WIDTH(SW), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW),
`ifdef PIPE_PERF_EN
    .StallCntW(sc3), .BubbleCntW(bc3),
`endif
    .bus(bus3.slave)
  );

  assign bus1.ValidM = in_valid;     assign bus3.ValidM = in_valid;
  assign bus1.RegWriteM = in_rw;     assign bus3.RegWriteM = in_rw;
  assign bus1.ResultSrcM = in_src;   assign bus3.ResultSrcM = in_src;
  assign bus1.RdM = in_rd;           assign bus3.RdM = in_rd;
  assign bus1.ALUResultM = in_alu;   assign bus3.ALUResultM = in_alu;
  assign bus1.ReadDataM = in_rdata;  assign bus3.ReadDataM = in_rdata;
  assign bus1.PCPlus4M = in_pc4;     assign bus3.PCPlus4M = in_pc4;

  logic [EW-1:0] cur_ent, obs1, obs3;
  assign cur_ent = {in_valid, in_rw, in_src, in_rd, in_alu, in_rdata, in_pc4};
  assign obs1 = {bus1.ValidW, bus1.RegWriteW, bus1.ResultSrcW, bus1.RdW,
                 bus1.ALUResultW, bus1.ReadDataW, bus1.PCPlus4W};
  assign obs3 = {bus3.ValidW, bus3.RegWriteW, bus3.ResultSrcW, bus3.RdW,
                 bus3.ALUResultW, bus3.ReadDataW, bus3.PCPlus4W};

  // scoreboard: one queue per instance; front entry is what the last stage must show
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q3[$];
  logic [31:0] stall_exp, bub1_exp, bub3_exp;
  int checks = 0;
  int failures = 0;

  function automatic logic [EW-1:0] out_of(logic [EW-1:0] e);
    logic [EW-1:0] r;
    r = e;
    r[EW-2] = e[EW-1] & e[EW-2];
    return r;
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    exp_q1.delete();
    exp_q3.delete();
    exp_q1.push_back('0);
    repeat (3) exp_q3.push_back('0);
    stall_exp = 0;
    bub1_exp  = 0;
    bub3_exp  = 0;
  endtask

  task automatic check_outputs(string tag);
    check({tag, "_d1"}, 128'(obs1), 128'(out_of(exp_q1[0])));
    check({tag, "_d3"}, 128'(obs3), 128'(out_of(exp_q3[0])));
`ifdef PIPE_PERF_EN
    check({tag, "_stall1"}, 128'(sc1), 128'(stall_exp));
    check({tag, "_stall3"}, 128'(sc3), 128'(stall_exp));
    check({tag, "_bub1"}, 128'(bc1), 128'(bub1_exp));
    check({tag, "_bub3"}, 128'(bc3), 128'(bub3_exp));
`endif
  endtask

  // driver: one rising edge with the current inputs, then model update and compare
  task automatic cycle(string tag);
    logic v1_pre, v3_pre;
    v1_pre = exp_q1[0][EW-1];
    v3_pre = exp_q3[0][EW-1];
    @(posedge clk);
    if (FlushW) begin
      for (int i = 0; i < exp_q1.size(); i++) exp_q1[i] = '0;
      for (int i = 0; i < exp_q3.size(); i++) exp_q3[i] = '0;
    end else if (!StallW) begin
      void'(exp_q1.pop_front());
      exp_q1.push_back(cur_ent);
      void'(exp_q3.pop_front());
      exp_q3.push_back(cur_ent);
    end
    if (StallW && !FlushW && stall_exp != 32'hFFFF_FFFF) stall_exp++;
    if (!v1_pre && bub1_exp != 32'hFFFF_FFFF) bub1_exp++;
    if (!v3_pre && bub3_exp != 32'hFFFF_FFFF) bub3_exp++;
    #1;
    check_outputs(tag);
  endtask

  task automatic set_in(logic v, logic rw, logic [SW-1:0] src, logic [AW-1:0] rd,
                        logic [DW-1:0] alu, logic [DW-1:0] rdata, logic [DW-1:0] pc4);
    in_valid = v; in_rw = rw; in_src = src; in_rd = rd;
    in_alu = alu; in_rdata = rdata; in_pc4 = pc4;
  endtask

  task automatic rand_in();
    set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), SW'($urandom_range(0, 3)),
           AW'($urandom_range(0, 31)), $urandom(), $urandom(), $urandom());
  endtask

  initial begin
    logic [31:0] s_before, b_before;
    rst = 1'b1;
    StallW = 1'b0;
    FlushW = 1'b0;
    rand_in();
    reset_model();

    // reset takes effect before any clock edge
    #2;
    check_outputs("reset_async");
    repeat (2) begin
      rand_in();
      @(posedge clk);
      #1;
      check_outputs("reset_hold");
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    reset_model();
    #1;
    check_outputs("reset_release");
    repeat (3) cycle("idle");

    // single valid item: DEPTH=1 sees it after one edge
    set_in(1, 1, 2'd0, 5'd5, 32'h0000_0010, 32'h0, 32'h104);
    cycle("stream");
    check("d1_alu", 128'(bus1.ALUResultW), 128'(32'h10));
    check("d1_rd", 128'(bus1.RdW), 128'(5));
    check("d1_rw", 128'(bus1.RegWriteW), 128'(1));
    check("d1_valid", 128'(bus1.ValidW), 128'(1));
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle("lat_1");
    check("d3_early", 128'(bus3.ValidW), 128'(0));
    cycle("lat_2");
    check("d3_pc4", 128'(bus3.PCPlus4W), 128'(32'h104));
    check("d3_valid", 128'(bus3.ValidW), 128'(1));
    cycle("lat_3");
    check("d3_after", 128'(bus3.ValidW), 128'(0));

    // inputs moving between edges must not reach the outputs
    rand_in();
    #2;
    check_outputs("no_comb");
    repeat (8) begin
      rand_in();
      cycle("rand_stream");
    end

    // two stall cycles while inputs keep changing
    s_before = stall_exp;
    StallW = 1'b1;
    rand_in();
    cycle("stall_1");
    rand_in();
    cycle("stall_2");
`ifdef PIPE_PERF_EN
    check("stall_cnt_plus2", 128'(sc1), 128'(s_before + 32'd2));
`endif
    StallW = 1'b0;
    repeat (4) begin
      rand_in();
      cycle("resume");
    end

    // flush together with stall kills the item in flight
    set_in(1, 1, 2'd1, 5'd9, 32'hAA, 32'hBB, 32'hCC);
    cycle("pre_flush");
    StallW = 1'b1;
    FlushW = 1'b1;
    rand_in();
    cycle("flush_stall");
    check("flush_valid", 128'(bus3.ValidW), 128'(0));
    check("flush_rw", 128'(bus3.RegWriteW), 128'(0));
    check("flush_alu", 128'(bus3.ALUResultW), 128'(0));
    check("flush_alu1", 128'(bus1.ALUResultW), 128'(0));
    StallW = 1'b0;
    FlushW = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (4) cycle("post_flush");

    // invalid slot: fields captured, writeback enable suppressed
    set_in(0, 1, 2'd2, 5'd7, 32'h55, 32'h66, 32'h77);
    cycle("invalid_slot");
    check("inv_rw", 128'(bus1.RegWriteW), 128'(0));
    check("inv_valid", 128'(bus1.ValidW), 128'(0));
    check("inv_rd", 128'(bus1.RdW), 128'(7));
    b_before = bub1_exp;
    cycle("invalid_bubble");
`ifdef PIPE_PERF_EN
    check("bubble_plus1", 128'(bc1), 128'(b_before + 32'd1));
`endif

    // reset mid-stall with valid data in flight
    set_in(1, 1, 2'd3, 5'd12, 32'h1234, 32'h5678, 32'h9ABC);
    repeat (3) cycle("refill");
    StallW = 1'b1;
    cycle("stall_before_rst");
    rst = 1'b1;
    reset_model();
    #1;
    check_outputs("rst_mid_stall");
    @(posedge clk);
    #1;
    rst = 1'b0;
    StallW = 1'b0;
    check_outputs("rst_release2");

    // random mix of stall / flush
    repeat (30) begin
      rand_in();
      StallW = ($urandom_range(0, 3) == 0);
      FlushW = ($urandom_range(0, 7) == 0);
      cycle("rand_mix");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
